// File: rtl/crc_encoding.sv
// Packet serializer: PID, ~PID, body and inverted CRC5/CRC16 as one MSB-first bit stream.
// First bit is valid the cycle after accept; a bit advances only on edges with bitReady=1, otherwise everything holds.
module crc_encoding #(
  parameter int MAX_BYTES = 8
) (
  input  logic                   clk,
  input  logic                   rst_b,
  input  logic [3:0]             pid,
  input  logic [6:0]             addr,
  input  logic [3:0]             endp,
  input  logic [8*MAX_BYTES-1:0] data,
  input  logic [3:0]             nbytes,
  input  logic                   pktInAvail,
  output logic                   readyIn,
  output logic                   bitOut,
  output logic                   bitOutAvail,
  input  logic                   bitReady,
  output logic                   last,
  output logic                   err
);

  localparam int          DW     = 8 * MAX_BYTES;
  localparam logic [3:0]  MAXB   = 4'(MAX_BYTES);
  localparam logic [4:0]  POLY5  = 5'b00101;
  localparam logic [15:0] POLY16 = 16'h8005;

  typedef enum logic [1:0] {S_IDLE, S_PID, S_BODY, S_CRC} state_t;

  state_t          state_q, state_d;
  logic [3:0]      pid_q, pid_d;
  logic [6:0]      addr_q, addr_d;
  logic [3:0]      endp_q, endp_d;
  logic [DW-1:0]   data_q, data_d;
  logic [3:0]      nbytes_q, nbytes_d;
  logic [6:0]      idx_q, idx_d;
  logic [4:0]      crc5_q, crc5_d;
  logic [15:0]     crc16_q, crc16_d;
  logic            err_q, err_d;

  logic            is_token, is_data, is_hs;
  logic            in_token, in_data, in_hs, in_ok;
  logic [6:0]      body_len, crc_len;
  logic            fire;
  logic [7:0]      pid_sh;
  logic [10:0]     tok_sh;
  logic [DW-1:0]   data_sh;
  logic [4:0]      crc5_sh;
  logic [15:0]     crc16_sh;
  logic            body_bit, crc_bit;
  logic            fb5, fb16;

  assign is_token = (pid_q[3:1] == 3'b100);
  assign is_data  = (pid_q[3:1] == 3'b110);
  assign is_hs    = (pid_q[3:1] == 3'b010);

  assign in_token = (pid[3:1] == 3'b100);
  assign in_data  = (pid[3:1] == 3'b110);
  assign in_hs    = (pid[3:1] == 3'b010);
  assign in_ok    = in_token | in_hs | (in_data & (nbytes <= MAXB));

  assign body_len = is_token ? 7'd11 : {nbytes_q, 3'b000};
  assign crc_len  = is_token ? 7'd5 : 7'd16;

  assign readyIn     = (state_q == S_IDLE);
  assign bitOutAvail = (state_q != S_IDLE);
  assign fire        = bitOutAvail & bitReady;
  assign err         = err_q;

  // Each field is left-shifted by the index so the current bit is always the field MSB.
  assign pid_sh   = {pid_q, ~pid_q} << idx_q;
  assign tok_sh   = {addr_q, endp_q} << idx_q;
  assign data_sh  = data_q << idx_q;
  assign crc5_sh  = crc5_q << idx_q;
  assign crc16_sh = crc16_q << idx_q;

  assign body_bit = is_token ? tok_sh[10] : data_sh[DW-1];
  assign crc_bit  = is_token ? ~crc5_sh[4] : ~crc16_sh[15];

  assign fb5  = crc5_q[4] ^ body_bit;
  assign fb16 = crc16_q[15] ^ body_bit;

  always_comb begin
    bitOut = 1'b0;
    last   = 1'b0;
    case (state_q)
      S_PID: begin
        bitOut = pid_sh[7];
        last   = is_hs && (idx_q == 7'd7);
      end
      S_BODY: bitOut = body_bit;
      S_CRC: begin
        bitOut = crc_bit;
        last   = (idx_q == crc_len - 7'd1);
      end
      default: ;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    pid_d    = pid_q;
    addr_d   = addr_q;
    endp_d   = endp_q;
    data_d   = data_q;
    nbytes_d = nbytes_q;
    idx_d    = idx_q;
    crc5_d   = crc5_q;
    crc16_d  = crc16_q;
    err_d    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (pktInAvail) begin
          pid_d    = pid;
          addr_d   = addr;
          endp_d   = endp;
          data_d   = data;
          nbytes_d = nbytes;
          idx_d    = 7'd0;
          crc5_d   = 5'h1F;
          crc16_d  = 16'hFFFF;
          if (in_ok) state_d = S_PID;
          else       err_d   = 1'b1;
        end
      end
      S_PID: begin
        if (fire) begin
          if (idx_q == 7'd7) begin
            idx_d = 7'd0;
            if (is_hs)                  state_d = S_IDLE;
            else if (body_len == 7'd0)  state_d = S_CRC;
            else                        state_d = S_BODY;
          end else begin
            idx_d = idx_q + 7'd1;
          end
        end
      end
      S_BODY: begin
        if (fire) begin
          if (is_token) crc5_d  = {crc5_q[3:0], 1'b0} ^ (fb5 ? POLY5 : 5'd0);
          else          crc16_d = {crc16_q[14:0], 1'b0} ^ (fb16 ? POLY16 : 16'd0);
          if (idx_q == body_len - 7'd1) begin
            idx_d   = 7'd0;
            state_d = S_CRC;
          end else begin
            idx_d = idx_q + 7'd1;
          end
        end
      end
      S_CRC: begin
        if (fire) begin
          if (idx_q == crc_len - 7'd1) begin
            idx_d   = 7'd0;
            state_d = S_IDLE;
          end else begin
            idx_d = idx_q + 7'd1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state_q  <= S_IDLE;
      pid_q    <= '0;
      addr_q   <= '0;
      endp_q   <= '0;
      data_q   <= '0;
      nbytes_q <= '0;
      idx_q    <= '0;
      crc5_q   <= 5'h1F;
      crc16_q  <= 16'hFFFF;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      pid_q    <= pid_d;
      addr_q   <= addr_d;
      endp_q   <= endp_d;
      data_q   <= data_d;
      nbytes_q <= nbytes_d;
      idx_q    <= idx_d;
      crc5_q   <= crc5_d;
      crc16_q  <= crc16_d;
      err_q    <= err_d;
    end
  end

endmodule

// File: doc/crc_encoding.md
Name: crc_encoding

Overview:
Transmit-side counterpart of the packet CRC decoder. Accepts one packet description per handshake: PID, token address/endpoint, and up to 8 data bytes. Serializes PID, complement PID, body and inverted CRC5/CRC16 as a single bit stream toward the line encoder (NRZI/bit-stuff stage). SYNC and EOP are added downstream and are not this block's job.

Parameters:
MAX_BYTES, 8, maximum data payload bytes; sets data width 8*MAX_BYTES.

Ports:
clk  input  1  system clock
rst_b  input  1  asynchronous active-low reset
pid  input  4  packet ID
addr  input  7  token address
endp  input  4  token endpoint
data  input  64  payload; byte 0 = data[63:56]
nbytes  input  4  payload byte count, 0..8
pktInAvail  input  1  packet fields valid
readyIn  output  1  block idle, can accept
bitOut  output  1  current serial bit
bitOutAvail  output  1  bitOut valid
bitReady  input  1  downstream consumes bitOut this cycle
last  output  1  bitOut is final bit of packet
err  output  1  one-cycle pulse: packet rejected

Behaviour:
- Clock and reset: one clock, clk. Reset rst_b is asynchronous and active-low.
- Reset values: state Idle; readyIn=1; bitOut=0, bitOutAvail=0, last=0, err=0; CRC registers all ones; counters 0. Reset mid-packet aborts the packet immediately. Nothing resumes after reset.
- Packet class from pid:
  - pid[3:1]=3'b100 is token: body 11 bits, CRC5.
  - pid[3:1]=3'b110 is data: body 8*nbytes bits, CRC16.
  - pid[3:1]=3'b010 is handshake: no body, no CRC.
  - Any other pid, or data with nbytes>8, is rejected: err pulses the cycle after acceptance, nothing is sent, and the block returns to Idle.
- Accept: pktInAvail && readyIn on a clk edge captures all fields. readyIn is low from the next cycle until the cycle after the last bit is consumed.
- States:
  - Idle → Pid on accept.
  - Pid (8 bits) → Body, or → Crc if body length is 0, or → Idle for a handshake.
  - Body → Crc.
  - Crc → Idle.
- Bit order, MSB first within every field:
  - PID field: pid[3:0], then ~pid[3:0].
  - Token body: addr[6:0], then endp[3:0].
  - Data body: byte 0..nbytes-1, each bit 7 first.
  - CRC field: inverted remainder, MSB first.
- Output handshake:
  - bitOutAvail=1 in Pid, Body and Crc; the first bit is valid the cycle after accept.
  - Bit advances only on an edge with bitReady=1. With bitReady=0, bitOut, last and the internal state hold.
  - last=1 together with the final bit. The edge that consumes it returns to Idle and drops bitOutAvail.
- CRC:
  - Computed over body bits only (not the PID), updated on each consumed body bit.
  - CRC5: poly x^5+x^2+1, init 5'b11111.
  - CRC16: poly x^16+x^15+x^2+1, init 16'hFFFF.
  - Per bit: fb = crc[MSB]^bit; crc = crc<<1; if fb, XOR with the poly low bits (5'b00101 / 16'h8005).
  - Remainder is frozen on entering Crc; the shift-out uses a separate index.
- Counters: 7-bit index, cleared on each state change. Max body 64 bits.
- Residue check: the emitted stream passed through the decoder must give residue 5'b01100 (token) or 16'h800D (data), and valid=1.
- Length rules: token 24 bits; handshake 8 bits; data 24+8*nbytes bits.
- pktInAvail while not Idle is ignored; no queuing.

Test Plan:
1. Token: pid=4'b1001, addr=0, endp=0, bitReady=1 → 24 bits 1001 0110 00000000000 01000; last on bit 24; readyIn back high the following cycle.
2. Handshake: pid=4'b0100 → 8 bits 0100 1011; last on bit 8; no CRC bits.
3. Zero-length data: pid=4'b1100, nbytes=0 → 1100 0011 followed by sixteen 0s (CRC 16'h0000); 24 bits total.
4. Data: nbytes=8, random payload, with bitReady toggling randomly → 88 bits; every bit held while bitReady=0; loopback through the decoder gives valid=1. Repeat with one payload bit flipped → valid=0.
5. Reject: pid=4'b0000, and separately data with nbytes=9 → err for 1 cycle; bitOutAvail stays 0; readyIn high again within 2 cycles.
6. Reset: assert rst_b=0 at data bit 40 → bitOutAvail=0 and readyIn=1 immediately. The next token sent after reset matches scenario 1 exactly.
